// File: rtl/hc4_ram_pkg.sv
// Shared types and helpers for the synchronous bus RAM.
// Parity storage is enabled by defining RAM_PARITY_EN.
package hc4_ram_pkg;

    typedef enum logic {
        CLEAR,
        IDLE
    } state_t;

    function automatic logic even_parity(input logic [31:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/ram_sync_core.sv
// Single-port storage: synchronous write, registered read.
// Unmapped read addresses return zero.
module ram_sync_core
    import hc4_ram_pkg::*;
#(
    parameter int MEM_W  = 4,
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 256
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic              i_re,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [MEM_W-1:0]  i_wdata,
    output logic [MEM_W-1:0]  o_rdata
);

    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

    logic [MEM_W-1:0] r_mem [DEPTH];
    logic [MEM_W-1:0] r_rdata;
    logic             w_mapped;

    assign w_mapped = {1'b0, i_addr} < DEPTH_L;

    always_ff @(posedge clk) begin
        if (i_we && w_mapped) begin
            r_mem[i_addr] <= i_wdata;
        end
        if (i_re) begin
            r_rdata <= w_mapped ? r_mem[i_addr] : '0;
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/memory_sync_bus_ram.sv
// Synchronous DATA_W x DEPTH RAM on a shared tristate bus with clear sweep.
// Optional parity column: define RAM_PARITY_EN.
module memory_sync_bus_ram
    import hc4_ram_pkg::*;
#(
    parameter int DATA_W = 4,
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] address,
    inout  wire  [DATA_W-1:0] data_bus,
    input  logic              nwrite_enable,
    input  logic              nread_enable,
    output logic              busy,
    output logic              rd_valid,
    output logic              bus_conflict,
    output logic              parity_err
);

`ifdef RAM_PARITY_EN
    localparam int MEM_W = DATA_W + 1;
`else
    localparam int MEM_W = DATA_W;
`endif
    localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W:0]   DEPTH_L = (ADDR_W+1)'(DEPTH);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [ADDR_W-1:0] r_cnt;
    logic [ADDR_W-1:0] w_cnt_nxt;
    logic              r_rd_valid;
    logic              r_conflict;
    logic              w_rv_nxt;
    logic              w_conf_nxt;
    logic              w_we;
    logic              w_re;
    logic [ADDR_W-1:0] w_addr;
    logic [MEM_W-1:0]  w_wdata;
    logic [MEM_W-1:0]  w_rdata;
    logic              w_mapped;
    logic [DATA_W-1:0] w_bus_in;

    assign w_bus_in = data_bus;
    assign w_mapped = {1'b0, address} < DEPTH_L;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= CLEAR;
            r_cnt      <= '0;
            r_rd_valid <= 1'b0;
            r_conflict <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_rd_valid <= w_rv_nxt;
            r_conflict <= w_conf_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_rv_nxt    = 1'b0;
        w_conf_nxt  = 1'b0;
        w_we        = 1'b0;
        w_re        = 1'b0;
        w_addr      = address;
`ifdef RAM_PARITY_EN
        w_wdata     = {even_parity(32'(w_bus_in)), w_bus_in};
`else
        w_wdata     = w_bus_in;
`endif
        unique case (r_state)
            CLEAR: begin
                // Zero word also carries zero parity
                w_we    = 1'b1;
                w_addr  = r_cnt;
                w_wdata = '0;
                if (r_cnt == LAST) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            IDLE: begin
                if (!nread_enable && !nwrite_enable) begin
                    w_conf_nxt = 1'b1;
                end else if (!nread_enable) begin
                    w_re     = 1'b1;
                    w_rv_nxt = 1'b1;
                end else if (!nwrite_enable) begin
                    // Bus still driven by us: the write data is not trustworthy
                    if (r_rd_valid) begin
                        w_conf_nxt = 1'b1;
                    end else begin
                        w_we = w_mapped;
                    end
                end
            end
        endcase
    end

    ram_sync_core #(
        .MEM_W  (MEM_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_core (
        .clk     (clk),
        .i_we    (w_we),
        .i_re    (w_re),
        .i_addr  (w_addr),
        .i_wdata (w_wdata),
        .o_rdata (w_rdata)
    );

    assign data_bus     = r_rd_valid ? w_rdata[DATA_W-1:0] : 'z;
    assign busy         = (r_state == CLEAR);
    assign rd_valid     = r_rd_valid;
    assign bus_conflict = r_conflict;

`ifdef RAM_PARITY_EN
    assign parity_err = r_rd_valid &&
        (w_rdata[DATA_W] != even_parity(32'(w_rdata[DATA_W-1:0])));
`else
    assign parity_err = 1'b0;
`endif

endmodule
